// File: rtl/rect_scan_counter_pkg.sv
// Shared encodings and default dimensions for the rectangle scan counter,
// the address ALU and the control FSM.
package rect_scan_counter_pkg;

  localparam int FS_W = 160;
  localparam int FS_H = 120;
  localparam int CV_W = 115;
  localparam int CV_H = 70;
  localparam int AN_W = 21;
  localparam int AN_H = 17;

  localparam int X_W = 8;
  localparam int Y_W = 7;

  typedef enum logic [1:0] {
    MODE_FULL    = 2'b00,
    MODE_CANVAS  = 2'b01,
    MODE_ANSWER  = 2'b10,
    MODE_INVALID = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef struct packed {
    logic [X_W-1:0] x0;
    logic [X_W-1:0] x_last;
    logic [Y_W-1:0] y_last;
  } dims_t;

  function automatic logic is_valid_mode(input logic [1:0] mode);
    return mode != MODE_INVALID;
  endfunction

endpackage

// File: rtl/rect_scan_counter_dim_lut.sv
// Maps a mode code to the scan's first X, last X and last Y.
module rect_dim_lut
  import rect_scan_counter_pkg::*;
#(
  parameter int FS_W_P = FS_W,
  parameter int FS_H_P = FS_H,
  parameter int CV_W_P = CV_W,
  parameter int CV_H_P = CV_H,
  parameter int AN_W_P = AN_W,
  parameter int AN_H_P = AN_H
) (
  input  logic [1:0] mode,
  output dims_t      dims
);

  // Fullscreen starts at X=1 and ends at FS_W because the address ALU
  // subtracts one in that mode; the invalid code falls back to fullscreen.
  always_comb begin
    dims.x0     = X_W'(1);
    dims.x_last = X_W'(FS_W_P);
    dims.y_last = Y_W'(FS_H_P - 1);
    case (mode)
      MODE_CANVAS: begin
        dims.x0     = '0;
        dims.x_last = X_W'(CV_W_P - 1);
        dims.y_last = Y_W'(CV_H_P - 1);
      end
      MODE_ANSWER: begin
        dims.x0     = '0;
        dims.x_last = X_W'(AN_W_P - 1);
        dims.y_last = Y_W'(AN_H_P - 1);
      end
      default: begin
        dims.x0     = X_W'(1);
        dims.x_last = X_W'(FS_W_P);
        dims.y_last = Y_W'(FS_H_P - 1);
      end
    endcase
  end

endmodule

// File: rtl/rect_scan_counter.sv
// Scans a mode-selected rectangle X-fastest, emitting one plot strobe per
// pixel with registered X/Y offsets for the address ALU.
module rect_scan_counter
  import rect_scan_counter_pkg::*;
#(
  parameter int FS_W_P = FS_W,
  parameter int FS_H_P = FS_H,
  parameter int CV_W_P = CV_W,
  parameter int CV_H_P = CV_H,
  parameter int AN_W_P = AN_W,
  parameter int AN_H_P = AN_H
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [1:0]     aluOp,
  input  logic           hold,
  output logic [X_W-1:0] Xpos,
  output logic [Y_W-1:0] Ypos,
  output logic           plot,
  output logic           busy,
  output logic           done,
  output logic [1:0]     modeOut
);

  state_e         state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           plot_q, plot_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [1:0]     mode_q, mode_d;
  logic [1:0]     lut_mode;
  dims_t          dims;

  // In IDLE the LUT looks at the incoming request so the first coordinate
  // can be loaded on the start edge; afterwards it follows the latched mode.
  assign lut_mode = (state_q == ST_IDLE) ? aluOp : mode_q;

  rect_dim_lut #(
    .FS_W_P(FS_W_P),
    .FS_H_P(FS_H_P),
    .CV_W_P(CV_W_P),
    .CV_H_P(CV_H_P),
    .AN_W_P(AN_W_P),
    .AN_H_P(AN_H_P)
  ) u_dim_lut (
    .mode(lut_mode),
    .dims(dims)
  );

  // A coordinate shown with plot=1 is written on the next edge, so it is
  // consumed even if hold rises then; a held coordinate is re-shown with
  // plot=1 once hold drops, keeping every pixel written exactly once.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    plot_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start && is_valid_mode(aluOp)) begin
          mode_d  = aluOp;
          x_d     = dims.x0;
          y_d     = '0;
          plot_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        busy_d = 1'b1;
        if (plot_q) begin
          if (x_q == dims.x_last && y_q == dims.y_last) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            plot_d = ~hold;
            if (x_q < dims.x_last) begin
              x_d = x_q + X_W'(1);
            end else begin
              x_d = dims.x0;
              if (y_q < dims.y_last) begin
                y_d = y_q + Y_W'(1);
              end
            end
          end
        end else begin
          plot_d = ~hold;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= MODE_FULL;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      plot_q  <= plot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
    end
  end

  assign Xpos    = x_q;
  assign Ypos    = y_q;
  assign plot    = plot_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign modeOut = mode_q;

endmodule

// File: tb/tb_rect_scan_counter.sv
// Bench for rect_scan_counter: expected pixel coordinates are queued when a
// scan is started and popped as the DUT raises plot.
module tb_rect_scan_counter;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic [1:0] aluOp;
   logic       hold;
   logic [7:0] Xpos;
   logic [6:0] Ypos;
   logic       plot;
   logic       busy;
   logic       done;
   logic [1:0] modeOut;

   int testsRun = 0;
   int testsFailed = 0;
   int expQ[$];
   int expMode = 0;

   rect_scan_counter dut (
      .clock(clock),
      .reset(reset),
      .start(start),
      .aluOp(aluOp),
      .hold(hold),
      .Xpos(Xpos),
      .Ypos(Ypos),
      .plot(plot),
      .busy(busy),
      .done(done),
      .modeOut(modeOut)
   );

   // Free-running clock; inputs are driven and outputs sampled on the falling edge
   always #5 clock = ~clock;

   // Hard stop in case a scan never terminates
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Count every comparison and report any difference
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Present a start request for exactly one clock edge
   task automatic applyStimulus(input logic startVal, input logic [1:0] op);
      start = startVal;
      aluOp = op;
      @(negedge clock);
      start = 1'b0;
   endtask

   // Reference rectangle dimensions for each mode
   task automatic modelDims(input logic [1:0] mode, output int x0, output int xLast, output int height);
      case (mode)
         2'b01:   begin x0 = 0; xLast = 114; height = 70; end
         2'b10:   begin x0 = 0; xLast = 20;  height = 17; end
         default: begin x0 = 1; xLast = 160; height = 120; end
      endcase
   endtask

   // Run one scan, optionally with a hold window, a mid-scan reset, a start
   // poke while busy, or a start on the done cycle
   task automatic runScan(input logic [1:0] mode, input int holdX, input int holdY, input int holdLen,
                          input int abortX, input int abortY, input int pokeAt, input bit b2b);
      int x0, xLast, height, total, budget, cycles, plots, holdLeft, zeroX, got;
      bit prevPlot, holdDone;
      modelDims(mode, x0, xLast, height);
      total = (xLast - x0 + 1) * height;
      expQ.delete();
      for (int y = 0; y < height; y++)
         for (int x = x0; x <= xLast; x++)
            expQ.push_back(y * 256 + x);
      budget = total + holdLen + 20;
      cycles = 0; plots = 0; holdLeft = 0; zeroX = 0;
      prevPlot = 1'b0; holdDone = 1'b0;
      applyStimulus(1'b1, mode);
      expMode = int'(mode);
      checkOutput("busyOnStart", busy, 1);
      while (1) begin
         start = 1'b0;
         if (cycles >= budget) begin
            checkOutput("scanTimeout", done, 1);
            return;
         end
         got = int'({Ypos, Xpos});
         if (mode == 2'b00 && Xpos == 8'd0) zeroX++;
         if (holdLeft > 0) begin
            checkOutput("holdPlot", plot, 0);
            checkOutput("holdXY", got, holdY * 256 + holdX);
            holdLeft--;
            if (holdLeft == 0) hold = 1'b0;
            prevPlot = 1'b0;
         end else if (done) begin
            checkOutput("doneAfterLast", prevPlot, 1);
            checkOutput("donePlot", plot, 0);
            checkOutput("doneBusy", busy, 1);
            checkOutput("plotCount", plots, total);
            checkOutput("queueEmpty", expQ.size(), 0);
            checkOutput("modeHeld", modeOut, mode);
            checkOutput("lastXY", got, (height - 1) * 256 + xLast);
            if (mode == 2'b00) checkOutput("fullXNonZero", zeroX, 0);
            if (b2b) begin
               start = 1'b1;
               aluOp = 2'b10;
               @(negedge clock);
               start = 1'b0;
               checkOutput("b2bIgnoredBusy", busy, 0);
               checkOutput("b2bIgnoredPlot", plot, 0);
               @(negedge clock);
               checkOutput("b2bStillIdle", busy, 0);
            end else begin
               @(negedge clock);
               checkOutput("idleBusy", busy, 0);
               checkOutput("idleDone", done, 0);
            end
            return;
         end else if (plot) begin
            if (expQ.size() == 0) begin
               checkOutput("extraPlot", plots, total - 1);
            end else begin
               checkOutput("pixelXY", got, expQ.pop_front());
            end
            plots++;
            prevPlot = 1'b1;
            if (!holdDone && int'(Xpos) == holdX - 1 && int'(Ypos) == holdY) begin
               hold = 1'b1;
               holdLeft = holdLen;
               holdDone = 1'b1;
            end
            if (pokeAt >= 0 && plots == pokeAt) begin
               start = 1'b1;
               aluOp = 2'b00;
            end
            if (int'(Xpos) == abortX && int'(Ypos) == abortY) begin
               #2 reset = 1'b1;
               #1;
               checkOutput("abortX", Xpos, 0);
               checkOutput("abortY", Ypos, 0);
               checkOutput("abortPlot", plot, 0);
               checkOutput("abortBusy", busy, 0);
               checkOutput("abortDone", done, 0);
               checkOutput("abortMode", modeOut, 0);
               #1 reset = 1'b0;
               expQ.delete();
               expMode = 0;
               repeat (3) begin
                  @(negedge clock);
                  checkOutput("noDoneAfterAbort", done, 0);
                  checkOutput("idleAfterAbort", busy, 0);
               end
               return;
            end
         end else begin
            checkOutput("plotGap", plot, 1);
            prevPlot = 1'b0;
         end
         @(negedge clock);
         cycles++;
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      hold  = 1'b0;
      aluOp = 2'b00;
      #12;
      checkOutput("rstX", Xpos, 0);
      checkOutput("rstY", Ypos, 0);
      checkOutput("rstPlot", plot, 0);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstDone", done, 0);
      checkOutput("rstMode", modeOut, 0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("postRstBusy", busy, 0);

      $display("[TB] answer scan");
      runScan(2'b10, -1, -1, 0, -1, -1, -1, 1'b0);

      $display("[TB] fullscreen scan");
      runScan(2'b00, -1, -1, 0, -1, -1, -1, 1'b0);

      $display("[TB] canvas scan with hold at (57,3)");
      runScan(2'b01, 57, 3, 5, -1, -1, -1, 1'b0);

      $display("[TB] invalid mode start");
      applyStimulus(1'b1, 2'b11);
      checkOutput("invalidBusy", busy, 0);
      checkOutput("invalidPlot", plot, 0);
      checkOutput("invalidMode", modeOut, expMode);
      @(negedge clock);
      checkOutput("invalidStillIdle", busy, 0);

      $display("[TB] answer scan with start poke while busy");
      runScan(2'b10, -1, -1, 0, -1, -1, 100, 1'b0);

      $display("[TB] canvas scan with reset at (10,5)");
      runScan(2'b01, -1, -1, 0, 10, 5, -1, 1'b0);
      runScan(2'b01, -1, -1, 0, -1, -1, -1, 1'b0);

      $display("[TB] back-to-back starts");
      runScan(2'b10, -1, -1, 0, -1, -1, -1, 1'b1);
      runScan(2'b10, -1, -1, 0, -1, -1, -1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
